alien_fleet_controller: RTL and testbench

- Owns the alien fleet state: 6x6 alive mask, fleet origin (xAlien, yAlien), march direction and win/lose status.
- Steps the fleet on each march tick from the slow TimeUnitEnable. Reverses and descends at the playfield edges.
- Resolves laser hits against the grid and returns a one-cycle killingAlien pulse to the Laser block.
- Feeds xAlien/yAlien/alive to ColorAlien.

---
 rtl/invaders_pkg.sv | 36 +++
 rtl/fleet_extent.sv | 42 ++++
 rtl/alien_fleet_controller.sv | 199 +++++++++++++++++++
 tb/tb_alien_fleet_controller.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared fleet geometry, screen bounds and controller state encoding.
// Also consumed by the alien colour renderer.
package invaders_pkg;

   localparam int unsigned COLS     = 6;
   localparam int unsigned ROWS     = 6;
   localparam int unsigned CELL_W   = 48;
   localparam int unsigned CELL_H   = 32;
   localparam int unsigned ALIEN_W  = 32;
   localparam int unsigned ALIEN_H  = 16;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   localparam int unsigned COORD_W  = 10;
   localparam int unsigned N_ALIENS = COLS * ROWS;
   localparam int unsigned COL_W    = $clog2(COLS);
   localparam int unsigned ROW_W    = $clog2(ROWS);
   localparam int unsigned IDX_W    = $clog2(N_ALIENS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIV_X,
      S_DIV_Y,
      S_KILL,
      S_MARCH,
      S_DONE
   } fleet_state_t;

   // Flat index into the alive mask for a (row, col) cell.
   function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
   endfunction

endpackage

// File: rtl/fleet_extent.sv
// Combinational extent of the living fleet: outermost alive columns and lowest alive row.
module fleet_extent
   import invaders_pkg::*;
(
   input  logic [N_ALIENS-1:0] alive,
   output logic [COL_W-1:0]    left_col,
   output logic [COL_W-1:0]    right_col,
   output logic [ROW_W-1:0]    bot_row,
   output logic                any_alive
);

   logic [COLS-1:0] col_occ;
   logic [ROWS-1:0] row_occ;

   always_comb begin
      col_occ   = '0;
      row_occ   = '0;
      left_col  = '0;
      right_col = '0;
      bot_row   = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (alive[r*COLS+c]) begin
               col_occ[c] = 1'b1;
               row_occ[r] = 1'b1;
            end
         end
      end
      // Descending scan leaves the lowest occupied column.
      for (int c = COLS - 1; c >= 0; c--) begin
         if (col_occ[c]) left_col = COL_W'(c);
      end
      for (int c = 0; c < COLS; c++) begin
         if (col_occ[c]) right_col = COL_W'(c);
      end
      for (int r = 0; r < ROWS; r++) begin
         if (row_occ[r]) bot_row = ROW_W'(r);
      end
      any_alive = |alive;
   end

endmodule

// File: rtl/alien_fleet_controller.sv
// Alien fleet state owner: marches the 6x6 grid, resolves laser hits by iterative
// division into (col,row) cells, and tracks sticky win/lose status.
module alien_fleet_controller
   import invaders_pkg::*;
#(
   parameter int unsigned STEP_X  = 4,
   parameter int unsigned STEP_Y  = 16,
   parameter int unsigned X_INIT  = 64,
   parameter int unsigned Y_INIT  = 32,
   parameter int unsigned X_MIN   = 8,
   parameter int unsigned X_MAX   = 631,
   parameter int unsigned Y_LIMIT = 400
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                marchTick,
   input  logic                laserCheck,
   input  logic [COORD_W-1:0]  xLaser,
   input  logic [COORD_W-1:0]  yLaser,
   output logic [COORD_W-1:0]  xAlien,
   output logic [COORD_W-1:0]  yAlien,
   output logic [N_ALIENS-1:0] alive,
   output logic                killingAlien,
   output logic                busy,
   output logic                gameWon,
   output logic                gameLost
);

   localparam int unsigned EXT_W  = COORD_W + 1;
   localparam int unsigned REMX_W = $clog2(COLS * CELL_W);
   localparam int unsigned REMY_W = $clog2(ROWS * CELL_H);

   fleet_state_t        state, state_d;
   logic                dir_left, dir_left_d;
   logic                pending, pending_d;
   logic [REMX_W-1:0]   rem_x, rem_x_d;
   logic [REMY_W-1:0]   rem_y, rem_y_d;
   logic [COL_W-1:0]    col, col_d;
   logic [ROW_W-1:0]    row, row_d;
   logic [COORD_W-1:0]  x_d, y_d;
   logic [N_ALIENS-1:0] alive_d;
   logic                busy_d, kill_d, won_d, lost_d;

   logic [COL_W-1:0]    left_col, right_col;
   logic [ROW_W-1:0]    bot_row;
   logic                any_alive;

   fleet_extent u_extent (
      .alive     (alive),
      .left_col  (left_col),
      .right_col (right_col),
      .bot_row   (bot_row),
      .any_alive (any_alive)
   );

   // Laser offset from the fleet origin and the grid bounding-box test.
   logic signed [COORD_W:0] dx, dy;
   logic                    in_grid;

   assign dx      = $signed({1'b0, xLaser}) - $signed({1'b0, xAlien});
   assign dy      = $signed({1'b0, yLaser}) - $signed({1'b0, yAlien});
   assign in_grid = !dx[COORD_W] && !dy[COORD_W]
                    && (dx[COORD_W-1:0] < COORD_W'(COLS * CELL_W))
                    && (dy[COORD_W-1:0] < COORD_W'(ROWS * CELL_H));

   logic [IDX_W-1:0] kill_idx;
   logic             hit;

   assign kill_idx = cell_index(row, col);
   assign hit      = (rem_x < REMX_W'(ALIEN_W)) && (rem_y < REMY_W'(ALIEN_H)) && alive[kill_idx];

   // Edge tests use only the columns that still hold a living alien.
   logic [EXT_W-1:0]   right_px, left_px, bottom_px;
   logic               can_step, invaded;
   logic [COORD_W-1:0] y_march;

   assign right_px  = EXT_W'(xAlien) + EXT_W'(right_col) * EXT_W'(CELL_W) + EXT_W'(ALIEN_W - 1 + STEP_X);
   assign left_px   = EXT_W'(xAlien) + EXT_W'(left_col) * EXT_W'(CELL_W);
   assign can_step  = dir_left ? (left_px >= EXT_W'(X_MIN + STEP_X)) : (right_px <= EXT_W'(X_MAX));
   assign y_march   = can_step ? yAlien : yAlien + COORD_W'(STEP_Y);
   assign bottom_px = EXT_W'(y_march) + EXT_W'(bot_row) * EXT_W'(CELL_H) + EXT_W'(ALIEN_H - 1);
   assign invaded   = bottom_px >= EXT_W'(Y_LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         dir_left     <= 1'b0;
         pending      <= 1'b0;
         rem_x        <= '0;
         rem_y        <= '0;
         col          <= '0;
         row          <= '0;
         xAlien       <= COORD_W'(X_INIT);
         yAlien       <= COORD_W'(Y_INIT);
         alive        <= '1;
         busy         <= 1'b0;
         killingAlien <= 1'b0;
         gameWon      <= 1'b0;
         gameLost     <= 1'b0;
      end else begin
         state        <= state_d;
         dir_left     <= dir_left_d;
         pending      <= pending_d;
         rem_x        <= rem_x_d;
         rem_y        <= rem_y_d;
         col          <= col_d;
         row          <= row_d;
         xAlien       <= x_d;
         yAlien       <= y_d;
         alive        <= alive_d;
         busy         <= busy_d;
         killingAlien <= kill_d;
         gameWon      <= won_d;
         gameLost     <= lost_d;
      end
   end

   always_comb begin
      state_d    = state;
      dir_left_d = dir_left;
      pending_d  = pending | marchTick;
      rem_x_d    = rem_x;
      rem_y_d    = rem_y;
      col_d      = col;
      row_d      = row;
      x_d        = xAlien;
      y_d        = yAlien;
      alive_d    = alive;
      busy_d     = busy;
      kill_d     = 1'b0;
      won_d      = gameWon;
      lost_d     = gameLost;

      case (state)
         S_IDLE: begin
            // Win check first, then laser, then a pending march.
            if (!any_alive) begin
               won_d   = 1'b1;
               state_d = S_DONE;
            end else if (laserCheck) begin
               rem_x_d = REMX_W'(dx[COORD_W-1:0]);
               rem_y_d = REMY_W'(dy[COORD_W-1:0]);
               col_d   = '0;
               row_d   = '0;
               if (in_grid) begin
                  busy_d  = 1'b1;
                  state_d = S_DIV_X;
               end
            end else if (pending) begin
               state_d = S_MARCH;
            end
         end
         S_DIV_X: begin
            if (rem_x >= REMX_W'(CELL_W)) begin
               rem_x_d = rem_x - REMX_W'(CELL_W);
               col_d   = col + COL_W'(1);
            end else begin
               state_d = S_DIV_Y;
            end
         end
         S_DIV_Y: begin
            if (rem_y >= REMY_W'(CELL_H)) begin
               rem_y_d = rem_y - REMY_W'(CELL_H);
               row_d   = row + ROW_W'(1);
            end else begin
               state_d = S_KILL;
            end
         end
         S_KILL: begin
            if (hit) begin
               alive_d[kill_idx] = 1'b0;
               kill_d            = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_MARCH: begin
            if (can_step) begin
               x_d = dir_left ? xAlien - COORD_W'(STEP_X) : xAlien + COORD_W'(STEP_X);
            end else begin
               dir_left_d = ~dir_left;
            end
            y_d       = y_march;
            pending_d = 1'b0;
            if (invaded) begin
               lost_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DONE: begin
            pending_d = pending;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alien_fleet_controller.sv
// Scoreboard bench for alien_fleet_controller: a fleet model predicts hit/march results,
// a monitor compares them as the DUT finishes each hit resolution or moves the fleet.
module tb_alien_fleet_controller;

   localparam int GW = 48, GH = 32, SW = 32, SH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        marchTick = 1'b0;
   logic        laserCheck = 1'b0;
   logic [9:0]  xLaser = '0;
   logic [9:0]  yLaser = '0;
   logic [9:0]  xAlien, yAlien;
   logic [35:0] alive;
   logic        killingAlien, busy, gameWon, gameLost;

   alien_fleet_controller dut (
      .clk          (clk),
      .reset        (reset),
      .marchTick    (marchTick),
      .laserCheck   (laserCheck),
      .xLaser       (xLaser),
      .yLaser       (yLaser),
      .xAlien       (xAlien),
      .yAlien       (yAlien),
      .alive        (alive),
      .killingAlien (killingAlien),
      .busy         (busy),
      .gameWon      (gameWon),
      .gameLost     (gameLost)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          kill;
      logic [35:0] alive;
      int          len;
   } laser_exp_t;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
   } pos_t;

   laser_exp_t lq[$];
   pos_t       pq[$];

   int errors = 0;
   int checks = 0;

   // Reference fleet
   int          mx, my;
   bit          mleft, mdone, mwon, mlost;
   logic [35:0] malive;

   function automatic void check(input string name, input longint unsigned act,
                                 input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      mx = 64; my = 32; mleft = 0; mdone = 0; mwon = 0; mlost = 0;
      malive = '1;
   endtask

   task automatic model_laser(input int xl, input int yl, output bit in_r);
      int dx, dy, c, r;
      laser_exp_t e;
      in_r = 0;
      if (mdone) return;
      dx = xl - mx;
      dy = yl - my;
      if (dx < 0 || dy < 0 || dx >= 6 * GW || dy >= 6 * GH) return;
      in_r = 1;
      c = dx / GW;
      r = dy / GH;
      e.kill = (dx % GW < SW) && (dy % GH < SH) && malive[r*6+c];
      if (e.kill) malive[r*6+c] = 1'b0;
      e.alive = malive;
      e.len   = c + r + 3;
      lq.push_back(e);
      if (malive == '0) begin mwon = 1; mdone = 1; end
   endtask

   task automatic model_march();
      int lc, rc, br;
      pos_t p;
      if (mdone) return;
      lc = 6; rc = -1; br = -1;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            if (malive[r*6+c]) begin
               if (c < lc) lc = c;
               if (c > rc) rc = c;
               if (r > br) br = r;
            end
      if (!mleft) begin
         if (mx + rc * GW + SW - 1 + 4 <= 631) mx += 4;
         else begin my += 16; mleft = 1; end
      end else begin
         if (mx + lc * GW - 4 >= 8) mx -= 4;
         else begin my += 16; mleft = 0; end
      end
      p.x = 10'(mx);
      p.y = 10'(my);
      pq.push_back(p);
      if (my + br * GH + SH - 1 >= 400) begin mlost = 1; mdone = 1; end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("queues_drained", lq.size() + pq.size(), 0);
      lq.delete();
      pq.delete();
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic check_reset_values();
      check("rst_x", xAlien, 64);
      check("rst_y", yAlien, 32);
      check("rst_alive", alive, 36'hF_FFFF_FFFF);
      check("rst_busy", busy, 0);
      check("rst_kill", killingAlien, 0);
      check("rst_won", gameWon, 0);
      check("rst_lost", gameLost, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("busy_timeout", busy, 0);
   endtask

   task automatic tick();
      @(negedge clk);
      marchTick = 1'b1;
      model_march();
      @(negedge clk);
      marchTick = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic laser(input int xl, input int yl);
      bit in_r;
      @(negedge clk);
      laserCheck = 1'b1;
      xLaser = 10'(xl);
      yLaser = 10'(yl);
      model_laser(xl, yl, in_r);
      @(negedge clk);
      laserCheck = 1'b0;
      if (!in_r) check("busy_no_division", busy, 0);
      wait_idle();
      repeat (3) @(negedge clk);
   endtask

   // Monitor: a falling busy closes a hit resolution; any fleet motion closes a march.
   initial begin : monitor
      int         blen;
      laser_exp_t e;
      pos_t       p;
      logic [9:0] px, py;
      blen = 0; px = 10'd64; py = 10'd32;
      forever begin
         @(negedge clk);
         if (reset) begin
            blen = 0; px = 10'd64; py = 10'd32;
         end else begin
            if (busy) begin
               blen++;
               check("kill_during_busy", killingAlien, 0);
            end else if (blen > 0) begin
               if (lq.size() == 0) check("laser_unexpected", 1, 0);
               else begin
                  e = lq.pop_front();
                  check("kill_pulse", killingAlien, e.kill);
                  check("alive_after_hit", alive, e.alive);
                  check("busy_cycles", blen, e.len);
               end
               blen = 0;
            end else begin
               check("kill_idle", killingAlien, 0);
            end
            if (xAlien != px || yAlien != py) begin
               if (pq.size() == 0) check("march_unexpected", {xAlien, yAlien}, {px, py});
               else begin
                  p = pq.pop_front();
                  check("march_x", xAlien, p.x);
                  check("march_y", yAlien, p.y);
               end
               px = xAlien; py = yAlien;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values();
      #1 reset = 1'b0;

      // Direct hit on cell 0, sprite gap, and a shot outside the grid.
      laser(64, 32);
      check("alive0_cleared", alive[0], 0);
      laser(64 + 40, 32);
      laser(10, 10);
      laser(64 + 6 * GW, 40);

      // Hit and tick in the same cycle; a second tick during the division is dropped.
      @(negedge clk);
      begin
         bit in_r;
         laserCheck = 1'b1; marchTick = 1'b1;
         xLaser = 10'(64 + GW + 3); yLaser = 10'(32 + 2 * GH + 2);
         model_laser(64 + GW + 3, 32 + 2 * GH + 2, in_r);
         model_march();
      end
      @(negedge clk);
      laserCheck = 1'b0; marchTick = 1'b1;
      @(negedge clk);
      marchTick = 1'b0;
      wait_idle();
      repeat (6) @(negedge clk);
      check("combined_x", xAlien, 68);

      // Reset in the middle of a division aborts the kill.
      do_reset();
      @(negedge clk);
      laserCheck = 1'b1; xLaser = 10'(64 + 5 * GW + 5); yLaser = 10'(32 + 5 * GH + 5);
      @(negedge clk);
      laserCheck = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_mid_division", busy, 1);
      #1 reset = 1'b1;
      @(negedge clk);
      check_reset_values();
      #1 reset = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_alive", alive, 36'hF_FFFF_FFFF);
      check("abort_busy", busy, 0);

      // Reset during a march cancels the pending tick.
      @(negedge clk);
      marchTick = 1'b1;
      @(negedge clk);
      marchTick = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_march_x", xAlien, 64);

      // Right edge: reverse and descend at xAlien=360.
      do_reset();
      n = 0;
      while (my == 32 && n < 200) begin tick(); n++; end
      check("edge_x", xAlien, 360);
      check("edge_y", yAlien, 48);
      tick();
      check("edge_back_x", xAlien, 356);

      // With column 5 gone, column 4 decides the reversal point.
      do_reset();
      for (int r = 0; r < 6; r++)
         laser(64 + 5 * GW + $urandom_range(0, SW - 1), 32 + r * GH + $urandom_range(0, SH - 1));
      check("col5_dead", alive & 36'h8_2082_0820, 0);
      n = 0;
      while (!mleft && n < 200) begin tick(); n++; end
      check("col4_edge_x", xAlien, 408);
      check("col4_edge_y", yAlien, 48);

      // Random mix of shots and ticks.
      do_reset();
      for (int i = 0; i < 80; i++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k < 5)
            laser(mx + $urandom_range(0, 5) * GW + $urandom_range(0, GW - 1),
                  my + $urandom_range(0, 5) * GH + $urandom_range(0, GH - 1));
         else if (k < 7)
            laser($urandom_range(0, 639), $urandom_range(0, 479));
         else
            tick();
      end

      // Clear the whole fleet.
      do_reset();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            laser(64 + c * GW + $urandom_range(0, SW - 1), 32 + r * GH + $urandom_range(0, SH - 1));
      check("win_flag", gameWon, 1);
      check("win_lost", gameLost, 0);
      check("win_alive", alive, 0);
      tick();
      check("win_frozen_x", xAlien, 64);

      // March untouched until the bottom row crosses the invasion line.
      do_reset();
      n = 0;
      while (!mdone && n < 2000) begin tick(); n++; end
      check("lost_flag", gameLost, 1);
      check("lost_won", gameWon, 0);
      check("lost_y", yAlien, 240);
      repeat (3) tick();
      laser(mx + 2, my + 2);
      check("lost_frozen_x", xAlien, 10'(mx));
      check("lost_frozen_y", yAlien, 240);
      check("lost_alive", alive, 36'hF_FFFF_FFFF);

      check("laser_queue_empty", lq.size(), 0);
      check("march_queue_empty", pq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
